// File: rtl/onehot_decoder_timed.sv
// Purpose : timed 3-to-8 decoder; code 0 drives line 7 and code 7 drives line 0.
//           The selected line is held for HOLD_CYCLES, then an optional idle GAP follows.
// Latency : the one-hot line is visible the cycle after the accepting edge.
//           done pulses for one cycle after the pulse ends.
// Backpr. : in_ready is high only in IDLE. Nothing is queued.
//           The producer holds in_code/in_valid until it sees in_ready.
// Ports   : clk/rst_n (async active-low) | in_valid, in_ready, in_code[2:0]
//           out_onehot[7:0], out_valid, last_code[2:0], done
module onehot_decoder_timed #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic [7:0] out_onehot,
  output logic       out_valid,
  output logic [2:0] last_code,
  output logic       done
);

  // A hold length of 0 would be meaningless, so it behaves as 1.
  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  // Counters load N-1 and run down to 0, giving exactly N cycles in the state.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    CNT_W'((GAP_CYCLES == 0) ? 32'd0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [2:0]       last_q, last_d;
  logic             done_q, done_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      onehot_q <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 3'b000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;     // done is a single-cycle pulse unless re-raised
    in_ready = (state_q == ST_IDLE);
    accept   = in_valid && in_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Bit (7 - code) is set; shifting the MSB right by the code is equivalent.
          onehot_d = 8'h80 >> in_code;
          valid_d  = 1'b1;
          last_d   = in_code;
          cnt_d    = HOLD_LOAD;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          onehot_d = 8'h00;
          valid_d  = 1'b0;
          done_d   = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign last_code  = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_onehot_decoder_timed.sv
// Purpose : directed self-checking bench for onehot_decoder_timed.
//           It uses three builds: HOLD=4/GAP=1, HOLD=1/GAP=0 and HOLD=0/GAP=1.
// Timing  : inputs are driven and outputs sampled 1ns after each rising edge.
module tb_onehot_decoder_timed;

  logic clk;
  logic rst_n;

  // Build A: HOLD=4, GAP=1
  logic       a_valid, a_ready, a_ovalid, a_done;
  logic [2:0] a_code, a_last;
  logic [7:0] a_onehot;
  // Build B: HOLD=1, GAP=0
  logic       b_valid, b_ready, b_ovalid, b_done;
  logic [2:0] b_code, b_last;
  logic [7:0] b_onehot;
  // Build C: HOLD=0 (behaves as 1), GAP=1
  logic       c_valid, c_ready, c_ovalid, c_done;
  logic [2:0] c_code, c_last;
  logic [7:0] c_onehot;

  int n_vec;
  int n_err;
  logic [7:0] sweep_exp [8];

  onehot_decoder_timed #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_code(a_code), .out_onehot(a_onehot), .out_valid(a_ovalid),
    .last_code(a_last), .done(a_done));

  onehot_decoder_timed #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_code(b_code), .out_onehot(b_onehot), .out_valid(b_ovalid),
    .last_code(b_last), .done(b_done));

  onehot_decoder_timed #(.HOLD_CYCLES(0), .GAP_CYCLES(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
    .in_code(c_code), .out_onehot(c_onehot), .out_valid(c_ovalid),
    .last_code(c_last), .done(c_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed check of {onehot, out_valid, in_ready, done}
  task automatic chk_a(input string tag, input logic [7:0] oh, input logic v,
                       input logic r, input logic d);
    chk_vec(tag, {21'd0, a_onehot, a_ovalid, a_ready, a_done}, {21'd0, oh, v, r, d});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] oh, input logic v,
                       input logic r, input logic d);
    chk_vec(tag, {21'd0, b_onehot, b_ovalid, b_ready, b_done}, {21'd0, oh, v, r, d});
  endtask

  task automatic chk_c(input string tag, input logic [7:0] oh, input logic v,
                       input logic r, input logic d);
    chk_vec(tag, {21'd0, c_onehot, c_ovalid, c_ready, c_done}, {21'd0, oh, v, r, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) chk_vec("a_done_excl_valid", {31'd0, a_done & a_ovalid}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sweep_exp[0] = 8'h80; sweep_exp[1] = 8'h40; sweep_exp[2] = 8'h20; sweep_exp[3] = 8'h10;
    sweep_exp[4] = 8'h08; sweep_exp[5] = 8'h04; sweep_exp[6] = 8'h02; sweep_exp[7] = 8'h01;
    rst_n = 1'b0;
    a_valid = 1'b0; a_code = 3'd0;
    b_valid = 1'b0; b_code = 3'd0;
    c_valid = 1'b0; c_code = 3'd0;

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    chk_a("rst_a", 8'h00, 1'b0, 1'b1, 1'b0);
    chk_vec("rst_last", {29'd0, a_last}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a("idle_a", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk_b("idle_b", 8'h00, 1'b0, 1'b1, 1'b0);
    chk_c("idle_c", 8'h00, 1'b0, 1'b1, 1'b0);

    // Full mapping sweep on A
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1;
      a_code  = 3'(k);
      chk_vec("sweep_ready", {31'd0, a_ready}, 32'd1);
      tick();
      a_valid = 1'b0;
      for (int h = 0; h < 4; h++) begin
        chk_a("sweep_hold", sweep_exp[k], 1'b1, 1'b0, 1'b0);
        chk_vec("sweep_last", {29'd0, a_last}, k);
        tick();
      end
      chk_a("sweep_done", 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk_a("sweep_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    end

    // Backpressure on A: code 7 waits through HOLD and GAP
    a_valid = 1'b1;
    a_code  = 3'd3;
    tick();
    a_code  = 3'd7;
    for (int h = 0; h < 4; h++) begin
      chk_a("bp_hold", 8'h10, 1'b1, 1'b0, 1'b0);
      chk_vec("bp_last", {29'd0, a_last}, 32'd3);
      tick();
    end
    chk_a("bp_done", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("bp_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    chk_a("bp_second", 8'h01, 1'b1, 1'b0, 1'b0);
    chk_vec("bp_last2", {29'd0, a_last}, 32'd7);
    repeat (5) tick();
    chk_a("bp_drain", 8'h00, 1'b0, 1'b1, 1'b0);

    // Back-to-back on B with in_valid held high
    b_valid = 1'b1;
    b_code  = 3'b010;
    tick();
    b_code  = 3'b101;
    chk_b("b2b_first", 8'h20, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("b2b_gap", 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    b_valid = 1'b0;
    chk_b("b2b_second", 8'h04, 1'b1, 1'b0, 1'b0);
    chk_vec("b2b_last", {29'd0, b_last}, 32'd5);
    tick();
    chk_b("b2b_done2", 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    chk_b("b2b_idle", 8'h00, 1'b0, 1'b1, 1'b0);

    // HOLD=0 build on C
    c_valid = 1'b1;
    c_code  = 3'b100;
    tick();
    c_valid = 1'b0;
    chk_c("h0_pulse", 8'h08, 1'b1, 1'b0, 1'b0);
    tick();
    chk_c("h0_done", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk_c("h0_idle", 8'h00, 1'b0, 1'b1, 1'b0);

    // Async reset in the second HOLD cycle on A
    a_valid = 1'b1;
    a_code  = 3'b000;
    tick();
    a_valid = 1'b0;
    tick();
    chk_a("arst_pre", 8'h80, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("arst_onehot", {24'd0, a_onehot}, 32'h00);
    chk_vec("arst_valid", {31'd0, a_ovalid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_a("arst_release", 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk_a("arst_idle", 8'h00, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_timed.md
Name: onehot_decoder_timed

Overview:
- Timed 3-to-8 decoder; the inverse of the team's 8-to-3 priority encoder.
- Code 3'b000 selects line 7, and 3'b111 selects line 0.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles.
- Inserts an optional idle gap after each pulse, then accepts the next code. Sits between code-producing control logic and strobe/select consumers.

Parameters:
HOLD_CYCLES, 4, cycles one-hot output stays asserted; legal 1..255; 0 treated as 1
GAP_CYCLES, 1, idle cycles forced after each pulse before next accept; legal 0..255
CNT_W, 8, down-counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset; one clock; asynchronous, active-low
in_valid  input  1  in_code valid this cycle
in_ready  output  1  block can accept; combinational, high only in IDLE
in_code  input  3  code to decode; sampled on accept
out_onehot  output  8  registered one-hot; bit (7 - in_code) set during HOLD, else 8'h00
out_valid  output  1  registered; high exactly while out_onehot is non-zero
last_code  output  3  registered; code of most recent accepted transfer
done  output  1  registered 1-cycle pulse on the cycle after HOLD ends

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, out_onehot=8'h00, out_valid=0, last_code=3'b000, done=0. in_ready=1 once rst_n is high.
- Reset mid-HOLD or mid-GAP clears outputs immediately, without waiting for a clock edge. No pending code survives reset.
- Accept: rising edge with in_valid && in_ready.
- FSM states: IDLE, HOLD, GAP.
- IDLE: in_ready=1; done=0.
  - On accept: out_onehot <= 8'b1 << (7 - in_code); out_valid <= 1; last_code <= in_code; counter <= HOLD_CYCLES-1; go to HOLD.
  - Latency: output is visible the cycle after the accepting edge.
- HOLD: in_ready=0; in_code/in_valid ignored.
  - counter != 0: decrement.
  - counter == 0: out_onehot <= 0, out_valid <= 0, done <= 1.
    - GAP_CYCLES == 0: go to IDLE.
    - Otherwise: counter <= GAP_CYCLES-1; go to GAP.
  - out_onehot is high for exactly HOLD_CYCLES cycles.
- GAP: in_ready=0; outputs zero; done <= 0 after its single cycle.
  - counter != 0: decrement.
  - counter == 0: go to IDLE.
  - Total idle after a pulse = GAP_CYCLES cycles, plus the IDLE cycle needed to accept.
- Minimum accept-to-accept spacing = HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- in_valid held high continuously: a new code is accepted on the first IDLE edge. No codes are queued. The producer must hold in_code stable until in_ready.
- in_valid with X/Z on in_code: no guarantee; the bench does not drive this.
- Decode is total: every 3-bit code maps to exactly one line; there is no invalid output state.
- Counter never wraps. It only decrements from a loaded value to 0.
- done is never high while out_valid is high.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, in_valid=0 for 10 cycles -> out_onehot=8'h00, out_valid=0, in_ready=1, done=0 throughout.
- Full mapping sweep (HOLD=4, GAP=1): send codes 0..7 sequentially -> out_onehot = 8'h80, 40, 20, 10, 08, 04, 02, 01. Each is high exactly 4 cycles starting 1 cycle after accept, and last_code matches each code.
- Back-to-back, GAP_CYCLES=0, HOLD_CYCLES=1: in_valid held high with codes 3'b010 then 3'b101 -> 8'h20 for 1 cycle, 1 zero cycle, then 8'h04 for 1 cycle. done pulses once after each.
- Backpressure: in_valid=1 during HOLD with code 3'b111 -> in_ready=0, output unchanged. The code is accepted only on the first IDLE edge, and 8'h01 follows after HOLD+GAP+1 cycles from the previous accept.
- Async reset mid-HOLD: assert rst_n low between clock edges in cycle 2 of HOLD with code 3'b000 -> out_onehot drops to 8'h00 before the next edge. After release, state is IDLE and in_ready=1.
- HOLD_CYCLES=0 build: code 3'b100 -> 8'h08 for exactly 1 cycle, then done pulse.
